// File: rtl/dfu_helper_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfu_helper_ctrl_pkg
// Description : Shared types and constants for the DFU boot helper: FSM
//               states, button pad modes, warm-boot image indices and the
//               debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
package dfu_helper_ctrl_pkg;

    // Boot helper FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_ARM  = 2'd2,
        ST_BOOT = 2'd3
    } state_t;

    // Button pad modes
    localparam int BTN_NONE       = 0;
    localparam int BTN_ACT_HIGH   = 1;
    localparam int BTN_ACT_LOW    = 2;
    localparam int BTN_ACT_LOW_PU = 3;

    // Warm-boot image indices
    localparam logic [1:0] IMG_BOOT = 2'd0;
    localparam logic [1:0] IMG_DFU  = 2'd1;
    localparam logic [1:0] IMG_APP  = 2'd2;

    // Consecutive disagreeing samples needed to flip the debounced level
    localparam int DEBOUNCE_LEN = 16;

    // Image a long press jumps to: an application build goes to DFU, a DFU
    // build goes back to the application.
    function automatic logic [1:0] long_press_sel(input int dfu_mode);
        return (dfu_mode != 0) ? IMG_APP : IMG_DFU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfu_helper_ctrl_warmboot.sv
`default_nettype none
// ============================================================================
// Module      : ice40_warmboot_wrap
// Description : Wrapper around the iCE40 SB_WARMBOOT primitive. Outside of
//               synthesis it is an empty stub so a simulation can observe the
//               BOOT/S lines on the parent's ports instead.
// Revision    : 1.0 - initial release
// ============================================================================
module ice40_warmboot_wrap (
    input  logic       boot,
    input  logic [1:0] sel
);

`ifdef SYNTHESIS
    SB_WARMBOOT u_warmboot (
        .BOOT (boot),
        .S1   (sel[1]),
        .S0   (sel[0])
    );
`else
    logic unused_wb;
    assign unused_wb = ^{boot, sel};
`endif

endmodule
`default_nettype wire

// File: rtl/dfu_helper_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dfu_helper_ctrl
// Description : Board boot helper. Synchronizes and debounces the user
//               button, times long presses (requesting system reset while
//               held) and triggers an iCE40 warm boot either on release
//               after a long press or on a software boot_now rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dfu_helper_ctrl
    import dfu_helper_ctrl_pkg::*;
#(
    parameter int TIMER_WIDTH = 24,
    parameter int BTN_MODE    = 3,
    parameter int DFU_MODE    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boot_now,
    input  logic [1:0] boot_sel,
    input  logic       btn_pad,
    output logic       btn_val,
    output logic       rst_req,
    output logic       wb_boot,
    output logic [1:0] wb_sel
);

    // Released pad level, so the synchronizer leaves reset already idle
    localparam logic       PAD_IDLE = (BTN_MODE == BTN_ACT_HIGH) ? 1'b0 : 1'b1;
    localparam logic [1:0] LONG_SEL = long_press_sel(DFU_MODE);
    localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE_LEN - 1);

    logic                   pad_in;
    logic                   sync1;
    logic                   sync2;
    logic                   norm_lvl;
    logic                   btn_lvl;
    logic [3:0]             db_cnt;
    logic [TIMER_WIDTH-1:0] press_tmr;
    logic                   long_press;
    logic                   boot_prev;
    logic                   sw_edge;
    state_t                 state;

    // Pad buffer: the pulled-up variant needs the SB_IO pull-up in hardware
    generate
        if (BTN_MODE == BTN_ACT_LOW_PU) begin : g_pad_pullup
`ifdef SYNTHESIS
            SB_IO #(
                .PIN_TYPE (6'b000001),
                .PULLUP   (1'b1)
            ) u_btn_io (
                .PACKAGE_PIN (btn_pad),
                .D_IN_0      (pad_in)
            );
`else
            assign pad_in = btn_pad;
`endif
        end else begin : g_pad_direct
            assign pad_in = btn_pad;
        end
    endgenerate

    // Polarity normalization: 1 always means pressed
    always_comb begin
        norm_lvl = 1'b0;
        case (BTN_MODE)
            BTN_ACT_HIGH:                norm_lvl = sync2;
            BTN_ACT_LOW, BTN_ACT_LOW_PU: norm_lvl = ~sync2;
            default:                     norm_lvl = 1'b0;
        endcase
    end

    // Two-flop synchronizer followed by the registered normalized level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= PAD_IDLE;
            sync2   <= PAD_IDLE;
            btn_lvl <= 1'b0;
        end else begin
            sync1   <= pad_in;
            sync2   <= sync1;
            btn_lvl <= norm_lvl;
        end
    end

    // Debounce: flip only after 16 consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt  <= 4'd0;
            btn_val <= 1'b0;
        end else if (btn_lvl != btn_val) begin
            if (db_cnt == DB_LAST) begin
                db_cnt  <= 4'd0;
                btn_val <= btn_lvl;
            end else begin
                db_cnt <= db_cnt + 4'd1;
            end
        end else begin
            db_cnt <= 4'd0;
        end
    end

    // Press timer: counts pressed cycles, saturating once the MSB is set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_tmr <= '0;
        end else if (!btn_val) begin
            press_tmr <= '0;
        end else if (!press_tmr[TIMER_WIDTH-1]) begin
            press_tmr <= press_tmr + TIMER_WIDTH'(1);
        end
    end

    assign long_press = press_tmr[TIMER_WIDTH-1];

    // Previous boot_now value; resets high so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            boot_prev <= 1'b1;
        end else begin
            boot_prev <= boot_now;
        end
    end

    assign sw_edge = boot_now & ~boot_prev;

    // Boot FSM with registered outputs; the software request outranks a release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rst_req <= 1'b0;
            wb_boot <= 1'b0;
            wb_sel  <= IMG_BOOT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sw_edge) begin
                        state   <= ST_ARM;
                        rst_req <= 1'b1;
                        wb_sel  <= boot_sel;
                    end else if (long_press) begin
                        state   <= ST_HELD;
                        rst_req <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (sw_edge) begin
                        state  <= ST_ARM;
                        wb_sel <= boot_sel;
                    end else if (!btn_val) begin
                        state  <= ST_ARM;
                        wb_sel <= LONG_SEL;
                    end
                end
                ST_ARM: begin
                    state   <= ST_BOOT;
                    wb_boot <= 1'b1;
                end
                ST_BOOT: begin
                    state <= ST_BOOT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ice40_warmboot_wrap u_warmboot (
        .boot (wb_boot),
        .sel  (wb_sel)
    );

endmodule
`default_nettype wire

// File: tb/tb_dfu_helper_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfu_helper_ctrl
// Description : Self-checking bench for dfu_helper_ctrl. Two instances share
//               the stimulus: an application build and a DFU build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfu_helper_ctrl;

    localparam int TW         = 8;
    localparam int LONG_CYC   = 1 << (TW - 1);  // pressed cycles to reach long
    localparam int PAD_TO_VAL = 19;             // pad edge to btn_val change

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       boot_now = 1'b0;
    logic [1:0] boot_sel = 2'b00;
    logic       btn_pad = 1'b1;

    logic       btn_val_a, rst_req_a, wb_boot_a;
    logic [1:0] wb_sel_a;
    logic       btn_val_d, rst_req_d, wb_boot_d;
    logic [1:0] wb_sel_d;

    int n_checks = 0;
    int n_fail   = 0;

    dfu_helper_ctrl #(.TIMER_WIDTH(TW), .BTN_MODE(3), .DFU_MODE(0)) dut_app (
        .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel),
        .btn_pad(btn_pad), .btn_val(btn_val_a), .rst_req(rst_req_a),
        .wb_boot(wb_boot_a), .wb_sel(wb_sel_a)
    );

    dfu_helper_ctrl #(.TIMER_WIDTH(TW), .BTN_MODE(3), .DFU_MODE(1)) dut_dfu (
        .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel),
        .btn_pad(btn_pad), .btn_val(btn_val_d), .rst_req(rst_req_d),
        .wb_boot(wb_boot_d), .wb_sel(wb_sel_d)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: image chosen by a long press for a given build
    function automatic logic [1:0] ref_long_sel(input int dfu_mode);
        return (dfu_mode != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        btn_pad  = 1'b1;
        boot_now = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Press the pad for len cycles and record when btn_val rose, how long it
    // stayed high and whether any reset/boot output ever asserted.
    task automatic press_observe(input int len, output int rise, output int width,
                                 output logic any_act);
        rise    = -1;
        width   = 0;
        any_act = 1'b0;
        btn_pad = 1'b0;
        for (int t = 1; t <= len + 60; t++) begin
            tick();
            if (t == len) btn_pad = 1'b1;
            if (btn_val_a && rise < 0) rise = t;
            if (btn_val_a) width++;
            if (rst_req_a || rst_req_d || wb_boot_a || wb_boot_d) any_act = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset();
        repeat (40) tick();
        n_checks++; if (btn_val_a !== 1'b0) begin n_fail++; $display("FAIL reset_btn_val_app: got %b want 0", btn_val_a); end
        n_checks++; if (rst_req_a !== 1'b0) begin n_fail++; $display("FAIL reset_rst_req_app: got %b want 0", rst_req_a); end
        n_checks++; if (wb_boot_a !== 1'b0) begin n_fail++; $display("FAIL reset_wb_boot_app: got %b want 0", wb_boot_a); end
        n_checks++; if (wb_sel_a !== 2'b00) begin n_fail++; $display("FAIL reset_wb_sel_app: got %b want 00", wb_sel_a); end
        n_checks++; if (btn_val_d !== 1'b0) begin n_fail++; $display("FAIL reset_btn_val_dfu: got %b want 0", btn_val_d); end
        n_checks++; if (rst_req_d !== 1'b0) begin n_fail++; $display("FAIL reset_rst_req_dfu: got %b want 0", rst_req_d); end
        n_checks++; if (wb_boot_d !== 1'b0) begin n_fail++; $display("FAIL reset_wb_boot_dfu: got %b want 0", wb_boot_d); end
        n_checks++; if (wb_sel_d !== 2'b00) begin n_fail++; $display("FAIL reset_wb_sel_dfu: got %b want 00", wb_sel_d); end
    endtask

    task automatic test_glitch;
        int rise, width, len;
        logic act;
        for (int i = 0; i < 4; i++) begin
            len = (i == 0) ? 15 : (i == 1) ? 10 : int'($urandom_range(1, 15));
            press_observe(len, rise, width, act);
            n_checks++;
            if (width !== 0 || act !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_len%0d: btn_val high %0d cycles act=%b, want 0 cycles act=0", len, width, act);
            end
        end
    endtask

    task automatic test_short_press;
        int rise, width, len;
        logic act;
        for (int i = 0; i < 4; i++) begin
            len = (i == 0) ? 16 : (i == 1) ? LONG_CYC - 1 : int'($urandom_range(17, 120));
            press_observe(len, rise, width, act);
            n_checks++; if (rise !== PAD_TO_VAL) begin n_fail++; $display("FAIL short_rise_len%0d: got %0d want %0d", len, rise, PAD_TO_VAL); end
            n_checks++; if (width !== len) begin n_fail++; $display("FAIL short_width_len%0d: got %0d want %0d", len, width, len); end
            n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL short_no_action_len%0d: got %b want 0", len, act); end
        end
    endtask

    task automatic test_long_press;
        int guard;
        int elapsed;
        do_reset();
        btn_pad = 1'b0;
        elapsed = 0;
        while (!btn_val_a && elapsed < 40) begin tick(); elapsed++; end
        n_checks++; if (elapsed !== PAD_TO_VAL) begin n_fail++; $display("FAIL long_btn_val_rise: got %0d want %0d", elapsed, PAD_TO_VAL); end
        repeat (LONG_CYC) tick();
        elapsed += LONG_CYC;
        n_checks++; if (rst_req_a !== 1'b0) begin n_fail++; $display("FAIL long_rst_req_early: got %b want 0", rst_req_a); end
        tick();
        elapsed++;
        n_checks++; if (rst_req_a !== 1'b1 || rst_req_d !== 1'b1) begin n_fail++; $display("FAIL long_rst_req: got %b/%b want 1/1", rst_req_a, rst_req_d); end
        repeat (300 - elapsed) tick();
        btn_pad = 1'b1;
        guard = 0;
        while (btn_val_a && guard < 40) begin tick(); guard++; end
        n_checks++; if (btn_val_a !== 1'b0) begin n_fail++; $display("FAIL long_release_timeout: btn_val %b want 0", btn_val_a); end
        n_checks++; if (wb_sel_a !== 2'b00 || wb_boot_a !== 1'b0) begin n_fail++; $display("FAIL long_held_outputs: sel %b boot %b want 00/0", wb_sel_a, wb_boot_a); end
        tick();
        n_checks++; if (wb_sel_a !== ref_long_sel(0) || wb_boot_a !== 1'b0) begin n_fail++; $display("FAIL long_arm_app: sel %b boot %b want %b/0", wb_sel_a, wb_boot_a, ref_long_sel(0)); end
        n_checks++; if (wb_sel_d !== ref_long_sel(1) || wb_boot_d !== 1'b0) begin n_fail++; $display("FAIL long_arm_dfu: sel %b boot %b want %b/0", wb_sel_d, wb_boot_d, ref_long_sel(1)); end
        tick();
        n_checks++; if (wb_boot_a !== 1'b1 || wb_boot_d !== 1'b1) begin n_fail++; $display("FAIL long_boot: got %b/%b want 1/1", wb_boot_a, wb_boot_d); end
        // Further requests and button activity are ignored once booting
        boot_sel = 2'b11;
        boot_now = 1'b1;
        tick();
        boot_now = 1'b0;
        btn_pad  = 1'b0;
        repeat (30) tick();
        btn_pad = 1'b1;
        n_checks++; if (wb_boot_a !== 1'b1 || wb_sel_a !== ref_long_sel(0) || rst_req_a !== 1'b1) begin n_fail++; $display("FAIL long_latched_app: boot %b sel %b rst %b want 1/%b/1", wb_boot_a, wb_sel_a, rst_req_a, ref_long_sel(0)); end
        n_checks++; if (wb_boot_d !== 1'b1 || wb_sel_d !== ref_long_sel(1)) begin n_fail++; $display("FAIL long_latched_dfu: boot %b sel %b want 1/%b", wb_boot_d, wb_sel_d, ref_long_sel(1)); end
    endtask

    task automatic test_sw_boot;
        logic [1:0] sel;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            sel = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) tick();
            boot_sel = sel;
            boot_now = 1'b1;
            tick();
            boot_now = 1'b0;
            n_checks++; if (wb_sel_a !== sel || wb_sel_d !== sel || wb_boot_a !== 1'b0) begin n_fail++; $display("FAIL sw_arm_%0d: sel %b/%b boot %b want %b/%b/0", i, wb_sel_a, wb_sel_d, wb_boot_a, sel, sel); end
            n_checks++; if (rst_req_a !== 1'b1) begin n_fail++; $display("FAIL sw_rst_req_%0d: got %b want 1", i, rst_req_a); end
            tick();
            n_checks++; if (wb_boot_a !== 1'b1 || wb_boot_d !== 1'b1) begin n_fail++; $display("FAIL sw_boot_%0d: got %b/%b want 1/1", i, wb_boot_a, wb_boot_d); end
            boot_sel = ~sel;
            boot_now = 1'b1;
            tick();
            boot_now = 1'b0;
            tick();
            n_checks++; if (wb_sel_a !== sel) begin n_fail++; $display("FAIL sw_ignore_%0d: sel %b want %b", i, wb_sel_a, sel); end
        end
    endtask

    task automatic test_boot_now_at_reset;
        rst_n    = 1'b0;
        btn_pad  = 1'b1;
        boot_now = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        n_checks++; if (wb_boot_a !== 1'b0 || rst_req_a !== 1'b0) begin n_fail++; $display("FAIL held_boot_now: boot %b rst %b want 0/0", wb_boot_a, rst_req_a); end
        boot_now = 1'b0;
        tick();
        boot_sel = 2'b10;
        boot_now = 1'b1;
        tick();
        boot_now = 1'b0;
        n_checks++; if (wb_sel_a !== 2'b10) begin n_fail++; $display("FAIL held_then_edge_sel: got %b want 10", wb_sel_a); end
        tick();
        n_checks++; if (wb_boot_a !== 1'b1) begin n_fail++; $display("FAIL held_then_edge_boot: got %b want 1", wb_boot_a); end
    endtask

    task automatic test_simultaneous;
        int guard;
        do_reset();
        btn_pad = 1'b0;
        guard = 0;
        while (!rst_req_a && guard < 250) begin tick(); guard++; end
        n_checks++; if (rst_req_a !== 1'b1) begin n_fail++; $display("FAIL simul_long_timeout: rst_req %b want 1", rst_req_a); end
        btn_pad = 1'b1;
        guard = 0;
        while (btn_val_a && guard < 40) begin tick(); guard++; end
        boot_sel = 2'b00;
        boot_now = 1'b1;
        tick();
        boot_now = 1'b0;
        n_checks++; if (wb_sel_a !== 2'b00 || wb_sel_d !== 2'b00) begin n_fail++; $display("FAIL simul_sw_wins: sel %b/%b want 00/00", wb_sel_a, wb_sel_d); end
        tick();
        n_checks++; if (wb_boot_a !== 1'b1) begin n_fail++; $display("FAIL simul_boot: got %b want 1", wb_boot_a); end
    endtask

    task automatic test_reset_in_boot;
        // Entered with both instances in BOOT
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++; if ({btn_val_a, rst_req_a, wb_boot_a, wb_sel_a} !== 5'b0) begin n_fail++; $display("FAIL boot_reset_app: got %b want 00000", {btn_val_a, rst_req_a, wb_boot_a, wb_sel_a}); end
        n_checks++; if ({btn_val_d, rst_req_d, wb_boot_d, wb_sel_d} !== 5'b0) begin n_fail++; $display("FAIL boot_reset_dfu: got %b want 00000", {btn_val_d, rst_req_d, wb_boot_d, wb_sel_d}); end
        boot_sel = 2'b01;
        boot_now = 1'b1;
        tick();
        boot_now = 1'b0;
        n_checks++; if (wb_sel_a !== 2'b01 || wb_boot_a !== 1'b0) begin n_fail++; $display("FAIL boot_reset_idle: sel %b boot %b want 01/0", wb_sel_a, wb_boot_a); end
        tick();
        n_checks++; if (wb_boot_a !== 1'b1) begin n_fail++; $display("FAIL boot_reset_reboot: got %b want 1", wb_boot_a); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_press();
        test_long_press();
        test_sw_boot();
        test_boot_now_at_reset();
        test_simultaneous();
        test_reset_in_boot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
